uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//   UART receive front end feeding the ALU command path. Synchronises the raw rxd
//   pin and locates each 8N1 frame (start, 8 data bits LSB first, stop). Each good
//   byte goes into a 1-entry valid/ready output buffer for the downstream consumer.
//   Reports framing errors and overruns as single-cycle pulses.
// PARAMETERS
//   CLKS_PER_BIT  104  clk_i cycles per UART bit (12 MHz / 115200); must be >= 4
//   SYNC_STAGES   2    flops in the rxd_i synchroniser; must be >= 2
// PORTS
//   clk_i        in   1  system clock
//   rst_ni       in   1  asynchronous active-low reset
//   rxd_i        in   1  raw serial input; idle high
//   data_o       out  8  received byte; valid only while valid_o=1
//   valid_o      out  1  data_o holds an unconsumed byte
//   ready_i      in   1  consumer accepts data_o when valid_o && ready_i
//   frame_err_o  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o    out  1  1-cycle pulse: good byte arrived while buffer full, byte discarded
// BEHAVIOUR
//   Reset (async assert, sync release): data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
//     Synchroniser flops reset to 1. FSM enters IDLE; bit counter and sample counter clear.
//   Reset during a frame abandons the frame without any pulse.
//   rxd_s is the output of the last synchroniser flop. All decisions use rxd_s only.
//   Sample counter cnt runs 0..CLKS_PER_BIT-1. Bit index runs 0..7.
//   FSM:
//     IDLE:  rxd_s==0 -> START, cnt=0.
//     START: at cnt==CLKS_PER_BIT/2-1, sample rxd_s.
//            If 1 (glitch) -> IDLE, no pulse. If 0 -> DATA, cnt=0, idx=0.
//     DATA:  at cnt==CLKS_PER_BIT-1, shift rxd_s into shreg[7] (right shift, LSB first) and set cnt=0.
//            After idx==7 is sampled -> STOP.
//     STOP:  at cnt==CLKS_PER_BIT-1, sample rxd_s.
//            If 1 -> deliver, then IDLE.
//            If 0 -> frame_err_o=1 for the next cycle, then BREAK.
//     BREAK: wait for rxd_s==1, then IDLE. A held-low line never starts a new frame.
//   Result: every sample lands at mid-bit, CLKS_PER_BIT/2 cycles after the start edge.
//   Deliver:
//     If buffer is empty, or valid_o && ready_i in the same cycle, data_o<=shreg and valid_o<=1.
//     Otherwise data_o is unchanged and overrun_o=1 for the next cycle.
//   Latency: valid_o rises on the clk_i edge after the stop-bit sample.
//     That is ~9.5*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the rxd_i falling edge.
//   Handshake:
//     valid_o && ready_i clears valid_o next cycle, unless a new byte loads the buffer in that same cycle.
//     data_o is stable while valid_o && !ready_i.
//     ready_i is ignored while valid_o==0.
//   frame_err_o and overrun_o never assert in the same cycle. Neither affects valid_o or data_o.
// TESTING (sim with CLKS_PER_BIT=16; ready_i=1 unless stated)
//   1 Send frame 0x55, then 0xA3 back-to-back -> valid_o pulses once per byte with data_o=0x55, then 0xA3;
//     no error pulses.
//   2 rxd_i low for 4 cycles, then high -> START rejects the glitch; no valid_o, no frame_err_o;
//     a following 0x3C frame is received correctly.
//   3 Frame 0x81 with stop bit low, line held low 40 bit-times -> exactly one frame_err_o pulse,
//     valid_o stays 0; after the line returns high, frame 0x7E is received.
//   4 ready_i=0; send 0x11, then 0x22 -> valid_o=1 with data_o=0x11 held; one overrun_o pulse at 0x22's stop;
//     raising ready_i gives one transfer of 0x11, then valid_o=0.
//   5 ready_i=0; send 0x11; raise ready_i exactly on the cycle 0x22 delivers -> no overrun;
//     data_o=0x22 and valid_o stays 1.
//   6 Assert rst_ni low mid-DATA of frame 0xF0 -> outputs 0 immediately; after release,
//     frame 0x0F yields data_o=0x0F with no spurious pulses.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer: synchronises rxd_i, samples each bit at mid-bit
// and hands good bytes to a 1-entry valid/ready buffer.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rxd_i        raw serial input, idle high
//   data_o       received byte, meaningful while valid_o=1
//   valid_o      data_o holds an unconsumed byte
//   ready_i      consumer accepts data_o when valid_o && ready_i
//   frame_err_o  1-cycle pulse: stop bit low, byte dropped
//   overrun_o    1-cycle pulse: byte arrived with buffer full, byte dropped
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic tick_half;
  logic tick_bit;
  logic fire;

  // Flops reset to 1 so an idle line is not seen as a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
    end
  end

  assign rxd_s     = sync_q[SYNC_STAGES-1];
  assign tick_half = (cnt_q == HALF);
  assign tick_bit  = (cnt_q == LAST);
  assign fire      = valid_q && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (tick_half) begin
          state_d = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_bit && idx_q == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_bit) begin
          state_d = rxd_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q && !ready_i;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      S_START: begin
        if (tick_half) cnt_d = '0;
        idx_d = '0;
      end
      S_DATA: begin
        if (tick_bit) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick_bit) begin
          cnt_d = '0;
          if (!rxd_s) begin
            ferr_d = 1'b1;
          end else if (!valid_q || fire) begin
            // A same-cycle drain frees the slot.
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: frame table, directed corner cases
// and random frames against a frame-level reference model.
module tb_uart_rx_deframer;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_ni;
  logic       rxd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  int checks;
  int failures;

  logic       rand_ready;
  logic       ready_man;
  logic [7:0] got_q[$];
  int         n_ferr;
  int         n_ovr;
  int         n_both;

  uart_rx_deframer #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rxd_i      (rxd_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive ready first, then record what the next posedge will transfer.
  always @(negedge clk) begin
    if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    else            ready_i = ready_man;
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    if (frame_err_o && overrun_o) n_both++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rxd_i = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge with the line high.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int hold, input int gap);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    for (int i = 0; i < hold; i++) bit_time(1'b0);
    for (int i = 0; i < gap; i++) bit_time(1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_xfer;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  int         b_x, b_f, b_o;
  logic [7:0] exp_q[$];
  int         exp_ferr;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
    vecs[1] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
    vecs[2] = '{8'h55, 1'b1, 0, 1, 8'h55, 0};
    vecs[3] = '{8'hA3, 1'b1, 0, 1, 8'hA3, 0};
    vecs[4] = '{8'h81, 1'b0, 2, 0, 8'h00, 1};
    vecs[5] = '{8'h3C, 1'b1, 0, 1, 8'h3C, 0};
    vecs[6] = '{8'hC5, 1'b0, 0, 0, 8'h00, 1};
    vecs[7] = '{8'h7E, 1'b1, 0, 1, 8'h7E, 0};

    checks     = 0;
    failures   = 0;
    n_ferr     = 0;
    n_ovr      = 0;
    n_both     = 0;
    rand_ready = 1'b0;
    ready_man  = 1'b1;
    ready_i    = 1'b1;
    rxd_i      = 1'b1;
    rst_ni     = 1'b0;

    repeat (3) @(negedge clk);
    check("reset data_o", data_o, 0);
    check("reset valid_o", valid_o, 0);
    check("reset frame_err_o", frame_err_o, 0);
    check("reset overrun_o", overrun_o, 0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    // Frame table
    for (int v = 0; v < 8; v++) begin
      b_x = got_q.size();
      b_f = n_ferr;
      b_o = n_ovr;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].hold, 2);
      check($sformatf("vec%0d xfers", v),
            got_q.size() - b_x, vecs[v].exp_xfer);
      if (vecs[v].exp_xfer == 1 && got_q.size() > b_x)
        check($sformatf("vec%0d data", v),
              got_q[b_x], vecs[v].exp_data);
      check($sformatf("vec%0d ferr", v),
            n_ferr - b_f, vecs[v].exp_ferr);
      check($sformatf("vec%0d ovr", v), n_ovr - b_o, 0);
    end

    // Back-to-back frames
    b_x = got_q.size(); b_f = n_ferr; b_o = n_ovr;
    send_frame(8'h55, 1'b1, 0, 0);
    send_frame(8'hA3, 1'b1, 0, 2);
    check("b2b xfers", got_q.size() - b_x, 2);
    if (got_q.size() - b_x == 2) begin
      check("b2b first", got_q[b_x], 8'h55);
      check("b2b second", got_q[b_x + 1], 8'hA3);
    end
    check("b2b ferr", n_ferr - b_f, 0);
    check("b2b ovr", n_ovr - b_o, 0);

    // Short glitch is rejected
    b_x = got_q.size(); b_f = n_ferr;
    rxd_i = 1'b0;
    repeat (4) @(negedge clk);
    rxd_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch xfers", got_q.size() - b_x, 0);
    check("glitch valid", valid_o, 0);
    check("glitch ferr", n_ferr - b_f, 0);
    send_frame(8'h3C, 1'b1, 0, 2);
    check("post-glitch xfers", got_q.size() - b_x, 1);
    if (got_q.size() > b_x)
      check("post-glitch data", got_q[b_x], 8'h3C);

    // Break: stop low, line held low ~40 bit times
    b_x = got_q.size(); b_f = n_ferr;
    send_frame(8'h81, 1'b0, 39, 2);
    check("break ferr", n_ferr - b_f, 1);
    check("break xfers", got_q.size() - b_x, 0);
    send_frame(8'h7E, 1'b1, 0, 2);
    check("post-break xfers", got_q.size() - b_x, 1);
    if (got_q.size() > b_x)
      check("post-break data", got_q[b_x], 8'h7E);
    check("post-break ferr", n_ferr - b_f, 1);

    // Overrun with a stalled consumer
    ready_man = 1'b0;
    repeat (2) @(negedge clk);
    b_x = got_q.size(); b_f = n_ferr; b_o = n_ovr;
    send_frame(8'h11, 1'b1, 0, 1);
    send_frame(8'h22, 1'b1, 0, 2);
    check("ovr valid held", valid_o, 1);
    check("ovr data held", data_o, 8'h11);
    check("ovr pulses", n_ovr - b_o, 1);
    check("ovr xfers", got_q.size() - b_x, 0);
    check("ovr ferr", n_ferr - b_f, 0);
    ready_man = 1'b1;
    repeat (4) @(negedge clk);
    check("drain xfers", got_q.size() - b_x, 1);
    if (got_q.size() > b_x)
      check("drain data", got_q[b_x], 8'h11);
    check("drain valid", valid_o, 0);

    // Drain on exactly the delivering edge (155 edges after start)
    ready_man = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h11, 1'b1, 0, 1);
    b_x = got_q.size(); b_o = n_ovr;
    fork
      begin
        @(negedge clk);
        send_frame(8'h22, 1'b1, 0, 2);
      end
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        #1 ready_man = 1'b1;
        @(posedge clk);
        #1 ready_man = 1'b0;
      end
    join
    check("same-cycle ovr", n_ovr - b_o, 0);
    check("same-cycle xfers", got_q.size() - b_x, 1);
    if (got_q.size() > b_x)
      check("same-cycle old data", got_q[b_x], 8'h11);
    check("same-cycle valid", valid_o, 1);
    check("same-cycle data", data_o, 8'h22);
    ready_man = 1'b1;
    repeat (4) @(negedge clk);

    // Reset mid-frame with a full buffer
    ready_man = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h5A, 1'b1, 0, 1);
    b_x = got_q.size(); b_f = n_ferr; b_o = n_ovr;
    fork
      send_frame(8'hF0, 1'b1, 0, 1);
      begin
        repeat (CPB * 4) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("rst valid", valid_o, 0);
        check("rst data", data_o, 0);
        check("rst ferr", frame_err_o, 0);
        check("rst ovr", overrun_o, 0);
      end
    join
    @(negedge clk);
    rst_ni = 1'b1;
    ready_man = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h0F, 1'b1, 0, 2);
    check("post-rst xfers", got_q.size() - b_x, 1);
    if (got_q.size() > b_x)
      check("post-rst data", got_q[b_x], 8'h0F);
    check("post-rst ferr", n_ferr - b_f, 0);
    check("post-rst ovr", n_ovr - b_o, 0);

    // Random frames vs frame-level model
    b_x = got_q.size(); b_f = n_ferr; b_o = n_ovr;
    exp_ferr = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      logic       good;
      b    = 8'($urandom);
      good = ($urandom_range(0, 99) < 80);
      if (good) begin
        exp_q.push_back(b);
        send_frame(b, 1'b1, 0, $urandom_range(0, 2));
      end else begin
        exp_ferr++;
        send_frame(b, 1'b0, $urandom_range(0, 3),
                   $urandom_range(1, 2));
      end
    end
    rand_ready = 1'b0;
    ready_man  = 1'b1;
    repeat (CPB * 2) @(negedge clk);
    check("rand xfers", got_q.size() - b_x, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b_x + i < got_q.size())
        check($sformatf("rand byte%0d", i),
              got_q[b_x + i], exp_q[i]);
    end
    check("rand ferr", n_ferr - b_f, exp_ferr);
    check("rand ovr", n_ovr - b_o, 0);
    check("ferr/ovr overlap", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
